// File: rtl/demux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : demux_rr_sched
// Brief   : Round-robin burst scheduler driving a 1-to-4 bit demux select.
// Revision: 1.0
// ============================================================================
module demux_rr_sched #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] dst_req,
  input  logic [3:0] dst_ready,
  output logic [1:0] addy,
  output logic       out_valid,
  output logic [3:0] grant,
  output logic       busy,
  output logic       burst_done,
  output logic       abort
);

  localparam logic [1:0]       c_st_idle   = 2'd0;
  localparam logic [1:0]       c_st_grant  = 2'd1;
  localparam logic [1:0]       c_st_xfer   = 2'd2;
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BURST_LEN - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  logic       w_xfer;
  logic       w_beat;
  logic       w_final;
  logic       w_req_lost;
  logic [1:0] w_start;
  logic [6:0] w_req_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_offs;
  logic [1:0] w_winner;

  assign w_xfer     = (r_state == c_st_xfer);
  assign in_ready   = w_xfer & dst_ready[addy];
  assign out_valid  = in_valid & in_ready;
  assign w_beat     = out_valid;
  assign grant      = w_xfer ? (4'b0001 << addy) : 4'b0000;
  assign busy       = (r_state == c_st_grant) | w_xfer;
  assign w_final    = (r_cnt == c_last_beat);
  assign w_req_lost = ~dst_req[addy];

  // Rotate the requests so bit 0 of w_rot is the slot right after the last winner.
  assign w_start   = r_last + 2'd1;
  assign w_req_dbl = {dst_req[2:0], dst_req};
  assign w_rot     = w_req_dbl[w_start +: 4];

  always_comb begin
    w_offs = 2'd3;
    if (w_rot[0])      w_offs = 2'd0;
    else if (w_rot[1]) w_offs = 2'd1;
    else if (w_rot[2]) w_offs = 2'd2;
  end

  assign w_winner = w_start + w_offs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_st_idle;
      addy       <= 2'b00;
      r_last     <= 2'b11;
      r_cnt      <= '0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      abort      <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (|dst_req) begin
            addy    <= w_winner;
            r_state <= c_st_grant;
          end
        end
        c_st_grant: begin
          r_cnt   <= '0;
          r_state <= c_st_xfer;
        end
        c_st_xfer: begin
          // A beat always wins over a dropped request in the same cycle.
          if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_final) begin
              burst_done <= 1'b1;
              r_last     <= addy;
              r_state    <= c_st_idle;
            end
          end else if (w_req_lost) begin
            abort   <= 1'b1;
            r_last  <= addy;
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_rr_sched
// Brief   : Self-checking bench for demux_rr_sched (BURST_LEN=4 and =1 builds).
// Revision: 1.0
// ============================================================================
module tb_demux_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid;
  logic [3:0] dst_req;
  logic [3:0] dst_ready;

  logic       in_ready0, out_valid0, busy0, done0, abort0;
  logic [1:0] addy0;
  logic [3:0] grant0;
  logic       in_ready1, out_valid1, busy1, done1, abort1;
  logic [1:0] addy1;
  logic [3:0] grant1;

  demux_rr_sched #(.BURST_LEN(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .dst_req(dst_req), .dst_ready(dst_ready), .addy(addy0), .out_valid(out_valid0),
    .grant(grant0), .busy(busy0), .burst_done(done0), .abort(abort0)
  );

  demux_rr_sched #(.BURST_LEN(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .dst_req(dst_req), .dst_ready(dst_ready), .addy(addy1), .out_valid(out_valid1),
    .grant(grant1), .busy(busy1), .burst_done(done1), .abort(abort1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the stream, how many beats remain.
  int m_owner [2];
  int m_left  [2];
  int m_last  [2];
  int m_addy  [2];
  int m_blen  [2];
  bit m_settle[2];
  bit m_done  [2];
  bit m_abort [2];

  task automatic model_reset(input int m);
    m_owner[m]  = -1;
    m_left[m]   = 0;
    m_last[m]   = 3;
    m_addy[m]   = 0;
    m_settle[m] = 1'b0;
    m_done[m]   = 1'b0;
    m_abort[m]  = 1'b0;
  endtask

  task automatic model_step(input int m);
    m_done[m]  = 1'b0;
    m_abort[m] = 1'b0;
    if (m_owner[m] < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last[m] + k) % 4;
        if (m_owner[m] < 0 && dst_req[idx]) begin
          m_owner[m]  = idx;
          m_addy[m]   = idx;
          m_settle[m] = 1'b1;
        end
      end
    end else if (m_settle[m]) begin
      m_settle[m] = 1'b0;
      m_left[m]   = m_blen[m];
    end else if (in_valid && dst_ready[m_owner[m]]) begin
      m_left[m]--;
      if (m_left[m] == 0) begin
        m_done[m]  = 1'b1;
        m_last[m]  = m_owner[m];
        m_owner[m] = -1;
      end
    end else if (!dst_req[m_owner[m]]) begin
      m_abort[m] = 1'b1;
      m_last[m]  = m_owner[m];
      m_owner[m] = -1;
    end
  endtask

  task automatic check_inst(input int m, input logic ir, input logic ov, input logic [3:0] g,
                            input logic b, input logic [1:0] a, input logic d, input logic ab);
    int e_ir, e_ov, e_g, e_b;
    e_ir = 0; e_ov = 0; e_g = 0; e_b = 0;
    if (m_owner[m] >= 0) begin
      e_b = 1;
      if (!m_settle[m]) begin
        e_ir = int'(dst_ready[m_owner[m]]);
        e_ov = e_ir & int'(in_valid);
        e_g  = 1 << m_owner[m];
      end
    end
    chk($sformatf("model%0d.in_ready", m),   int'(ir), e_ir);
    chk($sformatf("model%0d.out_valid", m),  int'(ov), e_ov);
    chk($sformatf("model%0d.grant", m),      int'(g),  e_g);
    chk($sformatf("model%0d.busy", m),       int'(b),  e_b);
    chk($sformatf("model%0d.addy", m),       int'(a),  m_addy[m]);
    chk($sformatf("model%0d.burst_done", m), int'(d),  int'(m_done[m]));
    chk($sformatf("model%0d.abort", m),      int'(ab), int'(m_abort[m]));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end
    check_inst(0, in_ready0, out_valid0, grant0, busy0, addy0, done0, abort0);
    check_inst(1, in_ready1, out_valid1, grant1, busy1, addy1, done1, abort1);
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] rdy;
    logic       vld;
    logic       ir;
    logic       ov;
    logic [3:0] g;
    logic       b;
    logic [1:0] a;
    logic       d;
    logic       ab;
  } vec_t;

  vec_t tbl[8];

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the drive point of the cycle after the GRANT settle cycle.
  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (busy0) seen = 1'b1;
      next_cycle();
    end
    chk({name, "_busy_seen"}, int'(seen), 1);
  endtask

  int   starts[8];
  int   scyc[8];
  int   beats[8];
  int   n, cnt, dones;
  logic [3:0] prev;
  logic [5:0] pat;
  bit   early, seen_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    m_blen[0] = 4;
    m_blen[1] = 1;
    model_reset(0);
    model_reset(1);
    reset = 1'b1; in_valid = 1'b0; dst_req = 4'b0; dst_ready = 4'b0;

    tbl[0] = '{4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[3] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[4] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[7] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset state plus a single burst to destination A.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dst_req = tbl[i].req; dst_ready = tbl[i].rdy; in_valid = tbl[i].vld;
      @(negedge clk);
      chk($sformatf("tbl%0d.in_ready", i),   int'(in_ready0),  int'(tbl[i].ir));
      chk($sformatf("tbl%0d.out_valid", i),  int'(out_valid0), int'(tbl[i].ov));
      chk($sformatf("tbl%0d.grant", i),      int'(grant0),     int'(tbl[i].g));
      chk($sformatf("tbl%0d.busy", i),       int'(busy0),      int'(tbl[i].b));
      chk($sformatf("tbl%0d.addy", i),       int'(addy0),      int'(tbl[i].a));
      chk($sformatf("tbl%0d.burst_done", i), int'(done0),      int'(tbl[i].d));
      chk($sformatf("tbl%0d.abort", i),      int'(abort0),     int'(tbl[i].ab));
      next_cycle();
    end

    // Fairness: all requesting, grants rotate 0,1,2,3,0 six cycles apart.
    dst_req = 4'b1111; dst_ready = 4'b1111; in_valid = 1'b1;
    do_reset();
    n = 0; prev = 4'b0;
    for (int i = 0; i < 8; i++) beats[i] = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (grant0 != 4'b0 && prev == 4'b0 && n < 5) begin
        starts[n] = int'(addy0); scyc[n] = c; n++;
      end
      if (out_valid0 && n > 0) beats[n-1]++;
      prev = grant0;
      next_cycle();
    end
    chk("fair_grant_count", n, 5);
    for (int i = 0; i < n && i < 5; i++) begin
      chk($sformatf("fair_addy%0d", i), starts[i], i % 4);
      chk($sformatf("fair_beats%0d", i), beats[i], 4);
      if (i > 0) chk($sformatf("fair_gap%0d", i), scyc[i] - scyc[i-1], 6);
    end

    // Back-pressure on destination C: beats only on ready cycles.
    dst_req = 4'b0100; dst_ready = 4'b0000; in_valid = 1'b1;
    do_reset();
    wait_busy("bp");
    pat = 6'b111001; cnt = 0; early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dst_ready = pat[i] ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (done0) early = 1'b1;
      if (out_valid0) cnt++;
      next_cycle();
    end
    dst_req = 4'b0000; dst_ready = 4'b0000;
    @(negedge clk);
    chk("bp_beats", cnt, 4);
    chk("bp_no_early_done", int'(early), 0);
    chk("bp_done_after_4th", int'(done0), 1);
    chk("bp_addy", int'(addy0), 2);
    next_cycle();

    // Abort on destination B after two beats, then re-arbitrate.
    dst_req = 4'b0010; dst_ready = 4'b1111; in_valid = 1'b0;
    do_reset();
    wait_busy("ab");
    in_valid = 1'b1;
    next_cycle();
    next_cycle();
    in_valid = 1'b0; dst_req = 4'b0000;
    @(negedge clk);
    chk("ab_grant_held", int'(grant0), 2);
    chk("ab_not_yet", int'(abort0), 0);
    next_cycle();
    dst_req = 4'b0011;
    @(negedge clk);
    chk("ab_pulse", int'(abort0), 1);
    chk("ab_no_done", int'(done0), 0);
    chk("ab_idle", int'(busy0), 0);
    next_cycle();
    @(negedge clk);
    chk("ab_next_busy", int'(busy0), 1);
    chk("ab_next_addy", int'(addy0), 0);
    chk("ab_single_pulse", int'(abort0), 0);
    next_cycle();

    // Asynchronous reset in the middle of a burst.
    dst_req = 4'b0001; dst_ready = 4'b1111; in_valid = 1'b1;
    do_reset();
    wait_busy("rst");
    @(negedge clk);
    chk("rst_first_beat", int'(out_valid0), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready0), 0);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_grant", int'(grant0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_no_done", int'(done0), 0);
    chk("rst_no_abort", int'(abort0), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    dst_req = 4'b1000;
    cnt = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      if (out_valid0) begin
        cnt++;
        chk("rst_new_addy", int'(addy0), 3);
      end
      if (done0) seen_done = 1'b1;
      next_cycle();
    end
    chk("rst_done_seen", int'(seen_done), 1);
    chk("rst_fresh_count", cnt, 4);

    // BURST_LEN=1 build: alternating single-beat grants between B and C.
    dst_req = 4'b0110; dst_ready = 4'b1111; in_valid = 1'b1;
    do_reset();
    n = 0; dones = 0; cnt = 0; prev = 4'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (grant1 != 4'b0 && prev == 4'b0 && n < 4) begin
        starts[n] = int'(addy1); n++;
      end
      if (done1) dones++;
      if (out_valid1) cnt++;
      prev = grant1;
      next_cycle();
    end
    chk("b1_grant_count", n, 4);
    for (int i = 0; i < n && i < 4; i++)
      chk($sformatf("b1_addy%0d", i), starts[i], (i % 2 == 0) ? 1 : 2);
    chk("b1_dones", dones, 4);
    chk("b1_beats", cnt, 4);

    // Randomised traffic; the negedge checker compares both builds to the model.
    dst_req = 4'b0; dst_ready = 4'b0; in_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) dst_req = 4'($urandom);
      dst_ready = 4'($urandom) | 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
Round-robin scheduler that shares one serial input stream among four destinations behind a 1-to-4 bit demultiplexer. It arbitrates between destination requests, drives the demux 2-bit address (addy), and gates the source handshake. Each grant lasts one burst of BURST_LEN beats. The block sits between the stream source and the demux select input.

Parameters:
BURST_LEN, 4, beats per grant; legal range 1..255.
CNT_W, 8, width of the beat counter; must satisfy BURST_LEN <= 2^CNT_W - 1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  source has a bit available this cycle.
in_ready  output  1  scheduler accepts the source bit this cycle.
dst_req  input  4  per-destination request; bit i maps to addy = i (0=A, 1=B, 2=C, 3=D).
dst_ready  input  4  per-destination ready to take a bit.
addy  output  2  demux select; registered.
out_valid  output  1  demux output bit is valid for destination addy.
grant  output  4  one-hot copy of the current grant; 0 when not in XFER.
busy  output  1  high in GRANT or XFER.
burst_done  output  1  one-cycle pulse when the final beat of a burst completes.
abort  output  1  one-cycle pulse when a burst ends early because its request dropped.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, addy=2'b00, last=2'b11, cnt=0, burst_done=0, abort=0. All combinational outputs then evaluate to 0: in_ready, out_valid, grant, busy.
- States: IDLE, GRANT, XFER.
- IDLE: if dst_req != 0, pick the winner by searching indices last+1, last+2, last+3, last+4 (mod 4). The first set bit wins.
  - Register addy <= winner and go to GRANT.
  - If dst_req == 0, stay in IDLE.
- GRANT: one settle cycle, so addy is stable before data flows. in_ready=0. Clear cnt, then go to XFER unconditionally.
- XFER:
  - in_ready = dst_ready[addy].
  - out_valid = in_valid & dst_ready[addy].
  - grant = one-hot(addy).
  - A beat is in_valid & in_ready; cnt increments on each beat.
- Normal completion: a beat with cnt == BURST_LEN-1 pulses burst_done on the next cycle, sets last <= addy, and returns to IDLE. Arbitration can start in that IDLE cycle, so the minimum gap between bursts is 2 cycles (IDLE, GRANT).
- Early termination: in XFER, if dst_req[addy]==0 and no beat occurs that cycle, pulse abort next cycle, set last <= addy, and go to IDLE.
  - If the request drops in the same cycle as a beat, the beat is accepted first. Termination is then evaluated on the next cycle.
  - If that beat is also the final beat, burst_done takes precedence and abort is not pulsed.
- Back-pressure: in_valid=1 with dst_ready[addy]=0 stalls with no beat; cnt holds and the state stays in XFER indefinitely.
- addy changes only on the IDLE->GRANT transition. It holds its value in IDLE after a burst, and the demux sees out_valid=0 then.
- BURST_LEN=1: every single beat completes a burst.
- Requests arriving mid-burst are ignored until IDLE. The grant is never pre-empted.
- Reset asserted mid-burst: the burst is abandoned immediately with no burst_done or abort pulse. After release, arbitration restarts with priority 0 first.
- burst_done and abort are registered and mutually exclusive.

Test Plan:
- Reset then dst_req=4'b0001, in_valid=1, dst_ready=4'b1111:
  - addy=0 from cycle 2.
  - in_ready high for exactly 4 cycles.
  - burst_done pulses once, then back to IDLE.
- Fairness: dst_req=4'b1111 held, all ready, in_valid=1 → grants in order addy=0,1,2,3,0. Each grant has 4 beats, separated by 2-cycle gaps.
- Back-pressure: granted addy=2, dst_ready[2] toggling 1,0,0,1,1,1 → beats counted only on the 1s. burst_done follows the 4th accepted beat, not the 4th cycle.
- Abort: grant addy=1, after 2 beats drop dst_req[1] with in_valid=0 → abort pulses once, no burst_done, last=1. With dst_req=4'b0011, the next grant is addy=0.
- Reset mid-burst: assert reset asynchronously after 1 beat → in_ready, out_valid, grant, busy drop immediately. After release, dst_req=4'b1000 gives addy=3 with a fresh count of 4.
- BURST_LEN=1 build: dst_req=4'b0110 → alternating grants 1,2,1,2, each with a single beat and a burst_done pulse.
